// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton frame sequencer.
package ca_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    localparam logic [7:0] RULE_TABLE [8] = '{
        8'd30, 8'd110, 8'd90, 8'd184,
        8'd54, 8'd150, 8'd73, 8'd45
    };

    function automatic logic [15:0] lfsr_step(
        input logic [15:0] s
    );
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/ca_btn_edge.sv
// Button synchroniser with press detection sampled only on frame ticks,
// so contact bounce shorter than a frame never produces a second press.
module ca_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic press
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (tick) prev <= sync;
        end
    end

    assign press = tick & sync & ~prev;

endmodule

// File: rtl/ca_frame_sequencer.sv
// Per-frame controller: rule selection, reseeding and scroll freeze
// for the 1-D cellular-automaton datapath.
module ca_frame_sequencer
    import ca_pkg::*;
#(
    parameter int NUM_RULES   = 8,
    parameter int AUTO_FRAMES = 600,
    parameter int SEED_FRAMES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         btn_next,
    input  logic                         btn_pause,
    input  logic                         btn_reseed,
    input  logic                         auto_en,
    input  logic                         seed_rand,
    output logic [7:0]                   rule,
    output logic [$clog2(NUM_RULES)-1:0] rule_idx,
    output logic                         seed_load,
    output logic                         seed_mode,
    output logic [15:0]                  seed_bits,
    output logic                         scroll_en,
    output logic                         paused
);

    localparam int IW = $clog2(NUM_RULES);
    localparam int CW = $clog2(AUTO_FRAMES + 1);
    localparam int SW = $clog2(SEED_FRAMES + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_RULES - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(AUTO_FRAMES - 1);
    localparam logic [SW-1:0] SEED_LAST = SW'(SEED_FRAMES);

    state_t        state, state_n;
    logic [IW-1:0] idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [SW-1:0] scnt_q, scnt_n;
    logic [15:0]   lfsr_q;
    logic [1:0]    sw_m, sw_s;
    logic          latch;
    logic          p_next, p_pause, p_reseed;

    ca_btn_edge u_next (
        .clk(clk), .reset(reset), .tick(frame_tick),
        .raw(btn_next), .press(p_next)
    );
    ca_btn_edge u_pause (
        .clk(clk), .reset(reset), .tick(frame_tick),
        .raw(btn_pause), .press(p_pause)
    );
    ca_btn_edge u_reseed (
        .clk(clk), .reset(reset), .tick(frame_tick),
        .raw(btn_reseed), .press(p_reseed)
    );

    function automatic logic [IW-1:0] inc_idx(
        input logic [IW-1:0] i
    );
        return (i == IDX_LAST) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        scnt_n  = scnt_q;
        latch   = 1'b0;
        if (frame_tick) begin
            if (p_reseed) begin
                // The frame that starts now is the first full seed frame.
                state_n = SEED;
                scnt_n  = SW'(1);
                latch   = 1'b1;
            end else begin
                case (state)
                    SEED: begin
                        if (scnt_q >= SEED_LAST) state_n = RUN;
                        else scnt_n = scnt_q + 1'b1;
                    end
                    RUN: begin
                        if (p_next) begin
                            idx_n = inc_idx(idx_q);
                            cnt_n = '0;
                        end else if (p_pause) begin
                            state_n = PAUSED;
                        end else if (sw_s[1]) begin
                            if (cnt_q == CNT_LAST) begin
                                idx_n = inc_idx(idx_q);
                                cnt_n = '0;
                            end else begin
                                cnt_n = cnt_q + 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (p_next) begin
                            idx_n = inc_idx(idx_q);
                            cnt_n = '0;
                        end else if (p_pause) begin
                            state_n = RUN;
                        end
                    end
                    default: state_n = SEED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEED;
            idx_q     <= '0;
            rule      <= RULE_TABLE[0];
            cnt_q     <= '0;
            scnt_q    <= '0;
            seed_mode <= 1'b0;
            seed_bits <= LFSR_INIT;
            lfsr_q    <= LFSR_INIT;
            sw_m      <= 2'b00;
            sw_s      <= 2'b00;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            sw_m   <= {auto_en, seed_rand};
            sw_s   <= sw_m;
            state  <= state_n;
            idx_q  <= idx_n;
            rule   <= RULE_TABLE[idx_n];
            cnt_q  <= cnt_n;
            scnt_q <= scnt_n;
            if (latch) begin
                seed_mode <= sw_s[0];
                seed_bits <= lfsr_q;
            end
        end
    end

    assign rule_idx  = idx_q;
    assign seed_load = (state == SEED);
    assign scroll_en = (state == RUN);
    assign paused    = (state == PAUSED);

endmodule
